// File: rtl/switch_mcu_pkg.sv
// Shared constants and types for the switch MCU core.
package switch_mcu_pkg;
  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/switch_mcu_regfile_rport.sv
// One registered read port: x0 masking, same-edge write forwarding and
// an output register that holds its value while the port is idle.
module switch_mcu_regfile_rport #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int BYPASS = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren,
  input  logic [REG_AW-1:0] in_raddr,
  input  logic [XLEN-1:0]   in_rword,
  input  logic              in_wen,
  input  logic [REG_AW-1:0] in_waddr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic [XLEN-1:0]   out_rdata
);
  import switch_mcu_pkg::*;

  logic [XLEN-1:0] value_p0;
  logic [XLEN-1:0] rdata_p1;

  function automatic logic [XLEN-1:0] sel_value(
    input logic [REG_AW-1:0] raddr,
    input logic [XLEN-1:0]   rword,
    input logic              wen,
    input logic [REG_AW-1:0] waddr,
    input logic [XLEN-1:0]   wdata
  );
    if (raddr == REG_AW'(ZERO_REG))
      return '0;
    else if ((BYPASS != 0) && wen && (waddr == raddr))
      return wdata;
    else
      return rword;
  endfunction

  // p0: address decode and forwarding
  always_comb begin
    value_p0 = sel_value(in_raddr, in_rword, in_wen, in_waddr, in_wdata);
  end

  // p1: registered read data
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      rdata_p1 <= '0;
    else if (in_ren)
      rdata_p1 <= value_p0;
  end

  assign out_rdata = rdata_p1;
endmodule

// File: rtl/switch_mcu_regfile.sv
// Architectural register file: 31 stored registers plus hard-wired x0,
// two read ports, a debug read port and a committed-write counter.
module switch_mcu_regfile #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int BYPASS = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren_1,
  input  logic [REG_AW-1:0] in_raddr_1,
  output logic [XLEN-1:0]   out_rdata_1,
  input  logic              in_ren_2,
  input  logic [REG_AW-1:0] in_raddr_2,
  output logic [XLEN-1:0]   out_rdata_2,
  input  logic              in_wen,
  input  logic [REG_AW-1:0] in_waddr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [REG_AW-1:0] in_dbg_raddr,
  output logic [XLEN-1:0]   out_dbg_rdata,
  output logic [15:0]       out_wr_cnt
);
  import switch_mcu_pkg::*;

  localparam int NREG = 1 << REG_AW;

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [15:0]     wr_cnt_q;
  logic            wr_commit;
  logic [XLEN-1:0] rword_1, rword_2, rword_dbg;

  assign wr_commit = in_wen && (in_waddr != REG_AW'(ZERO_REG));

  // Address 0 has no storage; the port masks it, the guard only avoids an
  // out-of-range lookup.
  assign rword_1   = (in_raddr_1   == REG_AW'(ZERO_REG)) ? '0 : regs[in_raddr_1];
  assign rword_2   = (in_raddr_2   == REG_AW'(ZERO_REG)) ? '0 : regs[in_raddr_2];
  assign rword_dbg = (in_dbg_raddr == REG_AW'(ZERO_REG)) ? '0 : regs[in_dbg_raddr];

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 1; i < NREG; i++)
        regs[i] <= '0;
      wr_cnt_q <= '0;
    end else if (wr_commit) begin
      regs[in_waddr] <= in_wdata;
      wr_cnt_q       <= wr_cnt_q + 16'd1;
    end
  end

  assign out_wr_cnt = wr_cnt_q;

  switch_mcu_regfile_rport #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS(BYPASS)) u_rport_1 (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_ren   (in_ren_1),
    .in_raddr (in_raddr_1),
    .in_rword (rword_1),
    .in_wen   (in_wen),
    .in_waddr (in_waddr),
    .in_wdata (in_wdata),
    .out_rdata(out_rdata_1)
  );

  switch_mcu_regfile_rport #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS(BYPASS)) u_rport_2 (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_ren   (in_ren_2),
    .in_raddr (in_raddr_2),
    .in_rword (rword_2),
    .in_wen   (in_wen),
    .in_waddr (in_waddr),
    .in_wdata (in_wdata),
    .out_rdata(out_rdata_2)
  );

  // Debug port samples every edge.
  switch_mcu_regfile_rport #(.XLEN(XLEN), .REG_AW(REG_AW), .BYPASS(BYPASS)) u_rport_dbg (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_ren   (1'b1),
    .in_raddr (in_dbg_raddr),
    .in_rword (rword_dbg),
    .in_wen   (in_wen),
    .in_waddr (in_waddr),
    .in_wdata (in_wdata),
    .out_rdata(out_dbg_rdata)
  );
endmodule
